button_reader: RTL and testbench
================================

Name: button_reader

Overview:
- Input-side counterpart to the LED output blocks: reads NUM_BTN raw pushbuttons from the board (16 MHz clock).
- Per channel: synchronizes and debounces the input, then reports a clean level plus single-cycle press, release and long-press events.
- Sits between the board pins and the control logic that drives the LEDs.

Parameters:
NUM_BTN, 2, number of independent button channels
ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed (pull-up board); 0 = pin reads 1 when pressed
DEBOUNCE_CNT, 200000, stable cycles required to accept a change (12.5 ms at 16 MHz); legal range >=2
LONG_CNT, 16000000, cycles held after the accepted press before long_pulse fires (1 s at 16 MHz); legal range >=2

Ports:
clk  in  1  system clock; the only clock, all logic on rising edge
rst  in  1  reset; asynchronous, active-high; clears all state
btn_in  in  NUM_BTN  raw button pins, asynchronous to clk
btn_level  out  NUM_BTN  debounced pressed state, 1 = pressed
press_pulse  out  NUM_BTN  1-cycle pulse on accepted press
release_pulse  out  NUM_BTN  1-cycle pulse on accepted release
long_pulse  out  NUM_BTN  1-cycle pulse once per press when the hold reaches LONG_CNT

Behaviour:
- Reset (async assert, any time, including mid-debounce): every output is 0, FSM is IDLE, counters are 0, sync flops hold logical "released". Outputs are all registered.
- Polarity: raw = btn_in XOR ACTIVE_LOW gives logical pressed=1. This inversion happens before synchronization.
- Synchronizer: two flops per channel. The FSM sees only the second-stage output s.
- Channel FSM, states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - IDLE: s=1 -> PRESS_WAIT, db_cnt<=0.
  - PRESS_WAIT: s=0 -> IDLE (bounce rejected, no pulse). Else if db_cnt==DEBOUNCE_CNT-1 -> PRESSED; btn_level<=1; press_pulse<=1; hold_cnt<=0. Else db_cnt++.
  - PRESSED: if hold_cnt<LONG_CNT, hold_cnt++ (saturates at LONG_CNT). When hold_cnt==LONG_CNT-1, long_pulse<=1 for exactly one cycle. s=0 -> RELEASE_WAIT, db_cnt<=0, hold_cnt frozen.
  - RELEASE_WAIT: s=1 -> PRESSED (bounce rejected; hold_cnt resumes from its frozen value; no pulse; long_pulse cannot re-fire if already fired). Else if db_cnt==DEBOUNCE_CNT-1 -> IDLE; btn_level<=0; release_pulse<=1. Else db_cnt++.
- Latency: raw input stable from the first clk edge that samples it pressed (edge 1) produces press_pulse high in the cycle after edge DEBOUNCE_CNT+3. Release has the same latency.
- Pulse timing:
  - press_pulse coincides with the first cycle of btn_level=1.
  - release_pulse coincides with the first cycle of btn_level=0.
  - Pulses never overlap within a channel.
- Long-press limits:
  - long_pulse fires at most once per accepted press.
  - A release accepted before the hold reaches LONG_CNT means long_pulse never fires.
- Widths: db_cnt is $clog2(DEBOUNCE_CNT) bits; hold_cnt is $clog2(LONG_CNT+1) bits. Counters never wrap.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- Glitch shorter than DEBOUNCE_CNT cycles: no output change at all.

Decomposition:
- Package btn_pkg:
  - state enum typedef btn_state_t (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT).
  - Default constants DEF_DEBOUNCE_CNT=200000 and DEF_LONG_CNT=16000000.
- Sub-module btn_channel: one synchronizer, FSM and counter set. The top generates NUM_BTN instances and applies polarity.

Test Plan (DEBOUNCE_CNT=4, LONG_CNT=10, ACTIVE_LOW=1, NUM_BTN=2):
- Reset then idle: btn_in=2'b11 for 50 cycles -> all outputs 0 throughout.
- Clean press: btn_in[0] 1->0 sampled at edge 1, then held -> press_pulse[0] high only in the cycle after edge 7; btn_level[0]=1 from then on.
- Long press: continue holding btn_in[0] -> long_pulse[0] high for exactly one cycle, 10 cycles after the press_pulse cycle; no second long_pulse after 40 more cycles.
- Bounce rejection:
  - Press side: btn_in[1] toggles every 2 cycles for 20 cycles, then returns to 1 -> btn_level[1] stays 0, no pulses.
  - Release side: while held, a 3-cycle high glitch -> btn_level stays 1, no release_pulse.
- Release plus simultaneity: release both channels on the same edge -> release_pulse=2'b11 in one cycle, DEBOUNCE_CNT+3 edges later; btn_level=2'b00.
- Reset mid-operation: assert rst asynchronously (between edges) while in PRESS_WAIT, and again in PRESSED -> outputs 0 immediately; after deassert with button held, a fresh press_pulse follows the full latency.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the pushbutton reader.
// The default counts assume a 16 MHz board clock.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // 12.5 ms debounce window and 1 s long-press threshold
    localparam int DEF_DEBOUNCE_CNT = 200000;
    localparam int DEF_LONG_CNT     = 16000000;

endpackage

// File: rtl/button_reader_if.sv
// Button bundle between the board-facing reader and its consumer.
// The master drives the raw pins; the reader (slave) returns the level and event pulses.
interface button_reader_if #(
    parameter int NUM_BTN = 2
);
    logic [NUM_BTN-1:0] btn_in;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] press_pulse;
    logic [NUM_BTN-1:0] release_pulse;
    logic [NUM_BTN-1:0] long_pulse;

    modport master (
        output btn_in,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_pulse
    );
endinterface

// File: rtl/btn_channel.sv
// One button channel: two-flop synchronizer, debounce FSM, and hold counter.
// Input is already polarity-corrected (1 = pressed); all outputs are registered.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
    parameter int LONG_CNT     = DEF_LONG_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int DB_W   = $clog2(DEBOUNCE_CNT);
    localparam int HOLD_W = $clog2(LONG_CNT + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CNT);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CNT - 1);

    logic              r_sync1;
    logic              r_sync2;
    btn_state_t        r_state;
    btn_state_t        w_state_next;
    logic [DB_W-1:0]   r_db_cnt;
    logic [DB_W-1:0]   w_db_cnt_next;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_cnt_next;
    logic              w_level_next;
    logic              w_press_next;
    logic              w_release_next;
    logic              w_long_next;
    logic              w_s;

    assign w_s = r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_state    <= IDLE;
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
            o_level    <= 1'b0;
            o_press    <= 1'b0;
            o_release  <= 1'b0;
            o_long     <= 1'b0;
        end else begin
            r_sync1    <= i_raw;
            r_sync2    <= r_sync1;
            r_state    <= w_state_next;
            r_db_cnt   <= w_db_cnt_next;
            r_hold_cnt <= w_hold_cnt_next;
            o_level    <= w_level_next;
            o_press    <= w_press_next;
            o_release  <= w_release_next;
            o_long     <= w_long_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:         if (w_s) w_state_next = PRESS_WAIT;
            PRESS_WAIT: begin
                if (!w_s)                   w_state_next = IDLE;
                else if (r_db_cnt == DB_LAST) w_state_next = PRESSED;
            end
            PRESSED:      if (!w_s) w_state_next = RELEASE_WAIT;
            RELEASE_WAIT: begin
                if (w_s)                    w_state_next = PRESSED;
                else if (r_db_cnt == DB_LAST) w_state_next = IDLE;
            end
            default:      w_state_next = IDLE;
        endcase
    end

    // Release detection wins over hold counting, so a press interrupted exactly at
    // LONG_CNT-1 fires its long pulse only if the release turns out to be a bounce.
    always_comb begin
        w_db_cnt_next   = r_db_cnt;
        w_hold_cnt_next = r_hold_cnt;
        w_level_next    = o_level;
        w_press_next    = 1'b0;
        w_release_next  = 1'b0;
        w_long_next     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_s) w_db_cnt_next = '0;
            end
            PRESS_WAIT: begin
                if (w_s) begin
                    if (r_db_cnt == DB_LAST) begin
                        w_level_next    = 1'b1;
                        w_press_next    = 1'b1;
                        w_hold_cnt_next = '0;
                    end else begin
                        w_db_cnt_next = r_db_cnt + 1'b1;
                    end
                end
            end
            PRESSED: begin
                if (!w_s) begin
                    w_db_cnt_next = '0;
                end else begin
                    if (r_hold_cnt < HOLD_MAX)   w_hold_cnt_next = r_hold_cnt + 1'b1;
                    if (r_hold_cnt == HOLD_FIRE) w_long_next     = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (!w_s) begin
                    if (r_db_cnt == DB_LAST) begin
                        w_level_next   = 1'b0;
                        w_release_next = 1'b1;
                    end else begin
                        w_db_cnt_next = r_db_cnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/button_reader.sv
// Reads NUM_BTN raw pushbuttons and reports debounced level plus press/release/long events.
// Polarity is normalised here so every channel works in "1 = pressed" terms.
module button_reader
    import btn_pkg::*;
#(
    parameter int NUM_BTN      = 2,
    parameter int ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
    parameter int LONG_CNT     = DEF_LONG_CNT
) (
    input  logic             clk,
    input  logic             rst,
    button_reader_if.slave   bus
);

    localparam logic POL = (ACTIVE_LOW != 0);

    logic [NUM_BTN-1:0] w_raw;
    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_release;
    logic [NUM_BTN-1:0] w_long;

    assign w_raw = bus.btn_in ^ {NUM_BTN{POL}};

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
            btn_channel #(
                .DEBOUNCE_CNT (DEBOUNCE_CNT),
                .LONG_CNT     (LONG_CNT)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .i_raw     (w_raw[gi]),
                .o_level   (w_level[gi]),
                .o_press   (w_press[gi]),
                .o_release (w_release[gi]),
                .o_long    (w_long[gi])
            );
        end
    endgenerate

    assign bus.btn_level     = w_level;
    assign bus.press_pulse   = w_press;
    assign bus.release_pulse = w_release;
    assign bus.long_pulse    = w_long;

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with DEBOUNCE_CNT=4, LONG_CNT=10, active-low pins.
// Every cycle's outputs are compared against hand-derived values.
module tb_button_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    button_reader_if #(.NUM_BTN(2)) bus_if ();

    button_reader #(
        .NUM_BTN      (2),
        .ACTIVE_LOW   (1),
        .DEBOUNCE_CNT (4),
        .LONG_CNT     (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Wait for the next rising edge, then settle 1 time unit before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed as {level, press, release, long}, 2 bits each.
    function automatic logic [7:0] ex(input logic [1:0] lv, input logic [1:0] pr,
                                      input logic [1:0] rl, input logic [1:0] lg);
        return {lv, pr, rl, lg};
    endfunction

    task automatic chk(input string tag, input int idx, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {bus_if.btn_level, bus_if.press_pulse, bus_if.release_pulse, bus_if.long_pulse};
        n_cmp++;
        $display("[%0t] %s[%0d] lvl/prs/rel/lng=%b", $time, tag, idx, obs);
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
        end
    endtask

    initial begin
        bus_if.btn_in = 2'b11;

        // Reset held, then idle for 50 cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("in_reset", i, 8'h00);
        end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle", i, 8'h00);
        end

        // Clean press on ch0; pulse after edge 7, long pulse after edge 17, never again
        bus_if.btn_in = 2'b10;
        for (int i = 1; i <= 60; i++) begin
            tick();
            chk("press0", i, ex((i >= 7) ? 2'b01 : 2'b00,
                                (i == 7) ? 2'b01 : 2'b00,
                                2'b00,
                                (i == 17) ? 2'b01 : 2'b00));
        end

        // Press-side bounce on ch1: 2-cycle runs never reach the debounce count
        for (int i = 0; i < 20; i++) begin
            bus_if.btn_in[1] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            chk("bounce1", i, ex(2'b01, 2'b00, 2'b00, 2'b00));
        end
        bus_if.btn_in[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("bounce1_tail", i, ex(2'b01, 2'b00, 2'b00, 2'b00));
        end

        // Release-side 3-cycle glitch on ch0 while held
        bus_if.btn_in[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("glitch0", i, ex(2'b01, 2'b00, 2'b00, 2'b00));
        end
        bus_if.btn_in[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("glitch0_tail", i, ex(2'b01, 2'b00, 2'b00, 2'b00));
        end

        // Clean press on ch1 while ch0 stays held
        bus_if.btn_in = 2'b00;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("press1", i, ex((i >= 7) ? 2'b11 : 2'b01,
                                (i == 7) ? 2'b10 : 2'b00,
                                2'b00,
                                (i == 17) ? 2'b10 : 2'b00));
        end

        // Simultaneous release of both channels
        bus_if.btn_in = 2'b11;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("release_both", i, ex((i >= 7) ? 2'b00 : 2'b11, 2'b00,
                                      (i == 7) ? 2'b11 : 2'b00, 2'b00));
        end

        // Async reset while ch0 is in PRESS_WAIT
        bus_if.btn_in = 2'b10;
        for (int i = 0; i < 4; i++) tick();
        #2 rst = 1'b1;
        #1 chk("rst_in_wait", 0, 8'h00);
        tick();
        chk("rst_in_wait", 1, 8'h00);
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("repress_a", i, ex((i >= 7) ? 2'b01 : 2'b00,
                                   (i == 7) ? 2'b01 : 2'b00, 2'b00, 2'b00));
        end

        // Async reset while ch0 is in PRESSED (level was 1)
        #3 rst = 1'b1;
        #1 chk("rst_in_pressed", 0, 8'h00);
        tick();
        chk("rst_in_pressed", 1, 8'h00);
        rst = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            tick();
            chk("repress_b", i, ex((i >= 7) ? 2'b01 : 2'b00,
                                   (i == 7) ? 2'b01 : 2'b00,
                                   2'b00,
                                   (i == 17) ? 2'b01 : 2'b00));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
